// File: rtl/bitty_pkg.sv
// bitty_pkg: shared encodings for the Bitty fetch unit and its branch evaluator
package bitty_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_DONE, UPDATE} fetch_state_t;
  localparam logic [1:0] FMT_R   = 2'b00;
  localparam logic [1:0] FMT_I   = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;
  localparam logic [1:0] COND_EQ = 2'b00;
  localparam logic [1:0] COND_GT = 2'b01;
  localparam logic [1:0] COND_LT = 2'b10;
  localparam logic [1:0] COND_NV = 2'b11;
  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_GT  = 2'b01;
  localparam logic [1:0] CMP_LT  = 2'b10;
endpackage

// File: rtl/bitty_fetch_unit_if.sv
// bitty_fetch_unit_if: instruction-memory request/valid bus
interface bitty_fetch_unit_if #(parameter int ADDR_W = 8) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  modport master (output mem_req, mem_addr, input mem_rdata, mem_valid);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_valid);
endinterface

// File: rtl/bitty_branch_eval.sv
// bitty_branch_eval: resolves branch-format instructions against the compare flags
module bitty_branch_eval import bitty_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic [15:0]       d_inst,
  input  logic [1:0]        cmp_result,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);
  assign taken  = d_inst[1:0] == FMT_BR && d_inst[3:2] != COND_NV && d_inst[3:2] == cmp_result;
  assign target = ADDR_W'(d_inst[15:4]);
endmodule

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: PC, instruction fetch handshake and issue/branch sequencing
module bitty_fetch_unit import bitty_pkg::*; #(
  parameter int ADDR_W      = 8,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                done,
  input  logic [1:0]          cmp_result,
  bitty_fetch_unit_if.master  mem,
  output logic [15:0]         d_inst,
  output logic                run,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                fault
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  fetch_state_t state;
  logic [CW-1:0] cnt;
  logic taken;
  logic [ADDR_W-1:0] target;
  bitty_branch_eval #(.ADDR_W(ADDR_W)) u_br (
    .d_inst(d_inst), .cmp_result(cmp_result), .taken(taken), .target(target)
  );
  assign mem.mem_addr = pc;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= PC0;
      d_inst      <= '0;
      mem.mem_req <= 1'b0;
      run         <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      cnt         <= '0;
    end else begin
      run <= 1'b0;
      case (state)
        IDLE: if (start && !fault) begin
          state       <= FETCH;
          mem.mem_req <= 1'b1;
          busy        <= 1'b1;
        end
        FETCH: if (mem.mem_valid) begin
          d_inst      <= mem.mem_rdata;
          cnt         <= '0;
          mem.mem_req <= 1'b0;
          run         <= 1'b1;
          state       <= ISSUE;
        end else if (cnt == LAST) begin
          fault       <= 1'b1;
          cnt         <= '0;
          mem.mem_req <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: if (done) state <= UPDATE;
        UPDATE: begin
          pc          <= taken ? target : pc + 1'b1;
          state       <= start ? FETCH : IDLE;
          mem.mem_req <= start;
          busy        <= start;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
